conv_window_sequencer: RTL and testbench
========================================

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 Parameter IMG, default 8: image side length in pixels; the image is IMG x IMG.
REQ-002 Parameter KW, default 3: kernel side length; the kernel is KW x KW.
REQ-003 Parameter DW, default 8: pixel width in bits, signed two's complement.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-006 in_st  input  1  one-cycle start pulse that begins a frame load.
REQ-007 din_valid  input  1  qualifies din during load.
REQ-008 din  input  DW  signed pixel; raster order, row 0 column 0 first.
REQ-009 load_ready  output  1  high while the block accepts pixels.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 pix  output  DW  signed pixel for the current kernel tap.
REQ-012 kidx  output  4  kernel tap index, ky*KW+kx, range 0..8.
REQ-013 mac_en  output  1  tap valid strobe to the MAC datapath.
REQ-014 mac_clr  output  1  first tap of a window (kidx=0); MAC clears its accumulator.
REQ-015 mac_last  output  1  final tap of a window (kidx=8); MAC result is complete.
REQ-016 win_row, win_col  output  3 each  output-pixel coordinate of the current window.
REQ-017 out_st  output  1  one-cycle frame-done pulse.

Function
REQ-018 The block SHALL hold an internal IMG*IMG x DW pixel buffer and implement a four-state FSM: IDLE, LOAD, RUN, DONE.
REQ-019 IDLE: when in_st=1, the block SHALL go to LOAD and clear the load counter; in_st SHALL be ignored in every other state.
REQ-020 LOAD: load_ready SHALL be 1; on each cycle with din_valid=1, the block SHALL write din to buffer[cnt] and increment cnt; gaps in din_valid SHALL stall the counter.
REQ-021 The edge that accepts beat 64 (cnt=63) SHALL move the FSM to RUN and drop load_ready; din_valid SHALL be ignored outside LOAD.
REQ-022 RUN: the block SHALL issue exactly one tap per cycle with mac_en=1, with no bubbles.
REQ-023 Window order SHALL be raster: win_col 0..5 inside win_row 0..5, giving (IMG-KW+1)^2 = 36 windows.
REQ-024 Tap order within a window SHALL be ky 0..2 outer, kx 0..2 inner.
REQ-025 Each tap SHALL drive pix = buffer[(win_row+ky)*IMG + (win_col+kx)] and kidx = ky*3+kx.
REQ-026 mac_clr SHALL be 1 exactly when kidx=0, and mac_last SHALL be 1 exactly when kidx=8; both SHALL be qualified by mac_en.
REQ-027 All outputs SHALL be registered.
REQ-028 Timing relative to edge E (the edge that accepts beat 64):
- first tap (window 0,0, kidx 0) SHALL appear after edge E+1;
- final mac_last (window 5,5) SHALL appear after edge E+324;
- the FSM SHALL enter DONE at edge E+325.
REQ-029 DONE: out_st=1 for exactly one cycle, then IDLE; mac_en=0 in DONE and IDLE.
REQ-030 When mac_en=0, pix, kidx, win_row and win_col SHALL hold their last values, and mac_clr and mac_last SHALL be 0.
REQ-031 Pixel values SHALL pass through unmodified, with sign preserved; there is no arithmetic on data.
REQ-032 An in_st that coincides with the out_st cycle SHALL be ignored; a new frame starts only from IDLE.

Reset
REQ-033 While reset=0, the block SHALL hold the following registers at their reset values:
- FSM = IDLE;
- all counters = 0;
- load_ready, busy, mac_en, mac_clr, mac_last, out_st = 0;
- pix, kidx, win_row, win_col = 0.
REQ-034 Buffer contents are not required to clear on reset.
REQ-035 Reset asserted mid-LOAD or mid-RUN SHALL abort the frame with no out_st, and the next in_st SHALL start a full 64-beat load.

Verification
REQ-036 Load din=index (0..63) with continuous din_valid -> window (0,0) taps = 0,1,2,8,9,10,16,17,18 with mac_clr on 0 and mac_last on 18; window (5,5) taps end with 63; out_st at E+325.
REQ-037 Load with din_valid toggling 1/0 -> 64 accepted beats take 127 cycles; the tap sequence is identical to REQ-036.
REQ-038 Pixel 0 = -128, pixel 9 = 127, rest 0 -> window (0,0) emits pix=-128 at kidx 0 and pix=127 at kidx 4; sign is intact.
REQ-039 in_st pulsed during LOAD, during RUN and on the out_st cycle -> no effect; exactly 324 mac_en cycles and one out_st per frame.
REQ-040 reset=0 for one cycle at RUN tap 100, then new in_st and full reload -> all outputs 0 during reset, no out_st for the aborted frame; the second frame matches REQ-036.
REQ-041 Two back-to-back frames (in_st the cycle after out_st) -> both produce 324 taps and an out_st; frame 2 taps reflect frame 2 data only.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: buffers one IMG x IMG frame, then streams
// every KW x KW window tap-by-tap to a downstream MAC.
module conv_window_sequencer #(
  parameter int IMG = 8,
  parameter int KW  = 3,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_st,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          load_ready,
  output logic          busy,
  output logic [DW-1:0] pix,
  output logic [3:0]    kidx,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last,
  output logic [2:0]    win_row,
  output logic [2:0]    win_col,
  output logic          out_st
);

  localparam int NPIX = IMG * IMG;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int NWIN = IMG - KW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    wr_q, wr_d;
  logic [2:0]    wc_q, wc_d;
  logic [3:0]    ky_q, ky_d;
  logic [3:0]    kx_q, kx_d;
  logic          run_end_q, run_end_d;

  logic          load_ready_q, load_ready_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [3:0]    kidx_q, kidx_d;
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          mac_last_q, mac_last_d;
  logic [2:0]    win_row_q, win_row_d;
  logic [2:0]    win_col_q, win_col_d;
  logic          out_st_q, out_st_d;

  logic [DW-1:0] mem [NPIX];
  logic          wr_en;
  logic [CW-1:0] rd_addr;
  logic          kx_end, ky_end, wc_end, wr_end;

  // Address of the tap under the current window/kernel counters.
  always_comb begin
    rd_addr = CW'((32'(wr_q) + 32'(ky_q)) * 32'(IMG)
                  + 32'(wc_q) + 32'(kx_q));
    kx_end  = (kx_q == 4'(KW - 1));
    ky_end  = (ky_q == 4'(KW - 1));
    wc_end  = (wc_q == 3'(NWIN - 1));
    wr_end  = (wr_q == 3'(NWIN - 1));
  end

  // Frame buffer; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt_q] <= din;
    end
  end

  // Next-state, counter advance and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    run_end_d  = run_end_q;
    wr_en      = 1'b0;
    pix_d      = pix_q;
    kidx_d     = kidx_q;
    win_row_d  = win_row_q;
    win_col_d  = win_col_q;
    mac_en_d   = 1'b0;
    mac_clr_d  = 1'b0;
    mac_last_d = 1'b0;
    out_st_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_st) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (din_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NPIX - 1)) begin
            state_d   = RUN;
            cnt_d     = '0;
            wr_d      = '0;
            wc_d      = '0;
            ky_d      = '0;
            kx_d      = '0;
            run_end_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (run_end_q) begin
          state_d   = DONE;
          out_st_d  = 1'b1;
          run_end_d = 1'b0;
        end else begin
          mac_en_d   = 1'b1;
          pix_d      = mem[rd_addr];
          kidx_d     = 4'(32'(ky_q) * 32'(KW) + 32'(kx_q));
          win_row_d  = wr_q;
          win_col_d  = wc_q;
          mac_clr_d  = (ky_q == '0) && (kx_q == '0);
          mac_last_d = ky_end && kx_end;
          kx_d = kx_q + 1'b1;
          if (kx_end) begin
            kx_d = '0;
            ky_d = ky_q + 1'b1;
            if (ky_end) begin
              ky_d = '0;
              wc_d = wc_q + 1'b1;
              if (wc_end) begin
                wc_d = '0;
                wr_d = wr_q + 1'b1;
                if (wr_end) begin
                  wr_d      = '0;
                  run_end_d = 1'b1;
                end
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    load_ready_d = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
  end

  // State, counters and all outputs register here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= '0;
      wc_q         <= '0;
      ky_q         <= '0;
      kx_q         <= '0;
      run_end_q    <= 1'b0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      pix_q        <= '0;
      kidx_q       <= '0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_last_q   <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      out_st_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      wc_q         <= wc_d;
      ky_q         <= ky_d;
      kx_q         <= kx_d;
      run_end_q    <= run_end_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      pix_q        <= pix_d;
      kidx_q       <= kidx_d;
      mac_en_q     <= mac_en_d;
      mac_clr_q    <= mac_clr_d;
      mac_last_q   <= mac_last_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      out_st_q     <= out_st_d;
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign pix        = pix_q;
  assign kidx       = kidx_q;
  assign mac_en     = mac_en_q;
  assign mac_clr    = mac_clr_q;
  assign mac_last   = mac_last_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign out_st     = out_st_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: random frames against a window-walk
// reference model with a queue scoreboard and a negedge monitor.
module tb_conv_window_sequencer;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_st = 1'b0;
  logic              din_valid = 1'b0;
  logic        [7:0] din = '0;
  logic              load_ready;
  logic              busy;
  logic signed [7:0] pix;
  logic        [3:0] kidx;
  logic              mac_en;
  logic              mac_clr;
  logic              mac_last;
  logic        [2:0] win_row;
  logic        [2:0] win_col;
  logic              out_st;

  conv_window_sequencer #(.IMG(8), .KW(3), .DW(8)) dut (
    .clk(clk), .reset(reset), .in_st(in_st),
    .din_valid(din_valid), .din(din),
    .load_ready(load_ready), .busy(busy), .pix(pix),
    .kidx(kidx), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_last(mac_last), .win_row(win_row),
    .win_col(win_col), .out_st(out_st)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int kidx;
    int row;
    int col;
  } tap_t;

  tap_t q[$];
  tap_t last_tap;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   e_cyc = 0;
  int   outs_exp = 0;
  int   outs_seen = 0;
  logic signed [7:0] frame [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: every window in raster order, taps ky-major.
  task automatic push_frame();
    tap_t t;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            t.pix  = int'(frame[(r + ky) * 8 + c + kx]);
            t.kidx = ky * 3 + kx;
            t.row  = r;
            t.col  = c;
            q.push_back(t);
          end
  endtask

  // Monitor: pops the scoreboard on every tap, checks hold/strobes.
  always @(negedge clk) begin
    tap_t e;
    if (reset) begin
      if (mac_en) begin
        if (q.size() == 0) begin
          chk("tap_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tap_pix", int'(pix), e.pix);
          chk("tap_kidx", int'(kidx), e.kidx);
          chk("tap_row", int'(win_row), e.row);
          chk("tap_col", int'(win_col), e.col);
          chk("tap_clr", int'(mac_clr), int'(e.kidx == 0));
          chk("tap_last", int'(mac_last), int'(e.kidx == 8));
          if (e.kidx == 0 && e.row == 0 && e.col == 0)
            chk("first_tap_lat", cyc - e_cyc, 1);
          last_tap = e;
        end
      end else begin
        chk("idle_clr", int'(mac_clr), 0);
        chk("idle_last", int'(mac_last), 0);
        chk("hold_pix", int'(pix), last_tap.pix);
        chk("hold_kidx", int'(kidx), last_tap.kidx);
        chk("hold_row", int'(win_row), last_tap.row);
        chk("hold_col", int'(win_col), last_tap.col);
      end
      if (out_st) begin
        outs_seen++;
        chk("done_lat", cyc - e_cyc, 325);
        chk("done_q_empty", q.size(), 0);
      end
    end
  end

  task automatic fill_index();
    for (int i = 0; i < 64; i++) frame[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
  endtask

  // Starts a frame from IDLE and feeds all 64 beats.
  task automatic load_frame(input bit gaps, input bit inject);
    int i;
    int bc;
    i  = 0;
    bc = 0;
    @(negedge clk);
    in_st = 1'b1;
    push_frame();
    @(negedge clk);
    in_st = 1'b0;
    chk("load_ready_up", int'(load_ready), 1);
    chk("busy_load", int'(busy), 1);
    while (i < 64) begin
      if (gaps && bc[0]) begin
        din_valid = 1'b0;
        din = 8'($urandom);
      end else begin
        din_valid = 1'b1;
        din = frame[i];
        i++;
      end
      in_st = inject && (bc == 20);
      @(posedge clk);
      #1;
      bc++;
      if (i == 64) e_cyc = cyc;
      else @(negedge clk);
    end
    chk("load_ready_down", int'(load_ready), 0);
    chk("busy_run", int'(busy), 1);
    @(negedge clk);
    din_valid = 1'b0;
    in_st = 1'b0;
  endtask

  // Waits (bounded) for out_st; optionally pulses in_st on it.
  task automatic wait_done(input bit inject);
    bit seen;
    seen = 1'b0;
    outs_exp++;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      if (out_st) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    if (inject) begin
      in_st = 1'b1;
      @(negedge clk);
      in_st = 1'b0;
      chk("idle_after_done", int'(busy), 0);
      @(negedge clk);
      chk("still_idle", int'(busy), 0);
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_load_ready", int'(load_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_clr_last", int'({mac_clr, mac_last}), 0);
    chk("rst_out_st", int'(out_st), 0);
    chk("rst_pix", int'(pix), 0);
    chk("rst_kidx", int'(kidx), 0);
    chk("rst_win", int'({win_row, win_col}), 0);
  endtask

  initial begin
    last_tap = '{0, 0, 0, 0};
    #12;
    check_reset_outs();
    @(negedge clk);
    reset = 1'b1;

    // Index ramp, continuous beats.
    fill_index();
    load_frame(1'b0, 1'b0);
    wait_done(1'b0);

    // Index ramp with 1/0 valid gaps.
    load_frame(1'b1, 1'b0);
    wait_done(1'b0);

    // Sign extremes.
    for (int i = 0; i < 64; i++) frame[i] = '0;
    frame[0] = -8'sd128;
    frame[9] = 8'sd127;
    load_frame(1'b0, 1'b0);
    wait_done(1'b0);

    // Random data, stray in_st in LOAD/RUN/out_st, din noise in RUN.
    fill_random();
    load_frame(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    in_st = 1'b1;
    din_valid = 1'b1;
    din = 8'($urandom);
    @(negedge clk);
    in_st = 1'b0;
    din_valid = 1'b0;
    wait_done(1'b1);

    // Abort mid-RUN at tap 100, then a clean reload.
    fill_random();
    load_frame(1'b0, 1'b0);
    repeat (99) @(negedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    last_tap = '{0, 0, 0, 0};
    #1;
    check_reset_outs();
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    fill_index();
    load_frame(1'b0, 1'b0);
    wait_done(1'b0);

    // Back-to-back frames with fresh random data.
    fill_random();
    load_frame(1'b0, 1'b0);
    wait_done(1'b0);
    fill_random();
    load_frame(1'b1, 1'b0);
    wait_done(1'b0);

    repeat (4) @(negedge clk);
    chk("out_st_count", outs_seen, outs_exp);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
